// File: rtl/nibbler_pkg.sv
// Shared definitions for the nibbler input port: debounce FSM states and defaults.
package nibbler_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } in_state_t;

   localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, cleared by the async active-low reset.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/in_port.sv
// Debounced 4-bit switch input port with read strobe, ready and overrun flags.
module in_port
   import nibbler_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] pins_in,
   input  logic       enableIn,
   output logic [3:0] data_out,
   output logic       bus_drive,
   output logic       data_ready,
   output logic       overrun
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [3:0]    sync_q;
   logic [3:0]    cand;
   logic [3:0]    held;
   logic [CW-1:0] cnt;
   in_state_t     state;
   logic          capture;

   sync2 #(.WIDTH(4)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pins_in),
      .q       (sync_q)
   );

   // Capture fires on the edge that sees the candidate still present with a full count.
   assign capture = (state == SETTLING) && (sync_q != held) &&
                    (sync_q == cand) && (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= STABLE;
         cand       <= '0;
         held       <= '0;
         cnt        <= '0;
         data_ready <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state)
            STABLE: begin
               if (sync_q != held) begin
                  cand  <= sync_q;
                  cnt   <= CNT_ONE;
                  state <= SETTLING;
               end
            end
            SETTLING: begin
               if (sync_q == held) begin
                  cnt   <= '0;
                  state <= STABLE;
               end else if (sync_q != cand) begin
                  cand <= sync_q;
                  cnt  <= CNT_ONE;
               end else if (cnt == CNT_MAX) begin
                  held  <= cand;
                  cnt   <= '0;
                  state <= STABLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= STABLE;
            end
         endcase

         // A read on the capture edge consumes the old nibble, so the new one stays pending.
         if (capture) begin
            data_ready <= 1'b1;
            if (enableIn)
               overrun <= 1'b0;
            else if (data_ready)
               overrun <= 1'b1;
         end else if (enableIn) begin
            data_ready <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

   assign data_out  = enableIn ? held : 4'b0;
   assign bus_drive = enableIn;

endmodule

// File: tb/tb_in_port.sv
// Directed bench for in_port with DEBOUNCE_CYCLES = 4 (capture 6 edges after first sample).
module tb_in_port;
   import nibbler_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [3:0] pins_in;
   logic       enableIn;
   logic [3:0] data_out;
   logic       bus_drive;
   logic       data_ready;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   in_port #(.DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pins_in    (pins_in),
      .enableIn   (enableIn),
      .data_out   (data_out),
      .bus_drive  (bus_drive),
      .data_ready (data_ready),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // New value on pins, then the 7th edge from now (first sample + 6) captures it.
   task automatic apply_and_capture(input logic [3:0] val);
      pins_in = val;
      repeat (7) step();
   endtask

   task automatic read_expect(input string tag, input logic [3:0] exp);
      enableIn = 1'b1;
      #1;
      check({tag, "_data"}, data_out, exp);
      check({tag, "_drive"}, bus_drive, 1'b1);
      step();
      enableIn = 1'b0;
      #1;
      check({tag, "_ready_clr"}, data_ready, 1'b0);
      check({tag, "_ovr_clr"}, overrun, 1'b0);
   endtask

   initial begin
      reset_n  = 1'b0;
      pins_in  = 4'h0;
      enableIn = 1'b0;
      step();
      step();

      // Reset state
      check("rst_ready", data_ready, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      check("rst_data", data_out, 4'h0);
      check("rst_drive", bus_drive, 1'b0);
      enableIn = 1'b1;
      #1;
      check("rst_en_data", data_out, 4'h0);
      check("rst_en_drive", bus_drive, 1'b1);
      enableIn = 1'b0;
      reset_n  = 1'b1;
      step();

      // Scenario 2: glitch of 5 for two cycles is rejected
      pins_in = 4'h5;
      step();
      step();
      pins_in = 4'h0;
      repeat (10) step();
      check("s2_ready", data_ready, 1'b0);
      check("s2_state", dut.state, STABLE);

      // Scenario 1: clean capture of A with exact latency
      pins_in = 4'hA;
      for (int i = 1; i <= 6; i++) begin
         step();
         check($sformatf("s1_pre%0d", i), data_ready, 1'b0);
      end
      step();
      check("s1_ready", data_ready, 1'b1);
      check("s1_idle_data", data_out, 4'h0);
      check("s1_idle_drive", bus_drive, 1'b0);
      read_expect("s1_read", 4'hA);

      // Scenario 3: bouncing 3/7 then 7 steady gives a single capture of 7
      for (int r = 0; r < 2; r++) begin
         pins_in = 4'h3;
         step();
         step();
         check($sformatf("s3_b3_%0d", r), data_ready, 1'b0);
         pins_in = 4'h7;
         step();
         step();
         check($sformatf("s3_b7_%0d", r), data_ready, 1'b0);
         pins_in = 4'h3;
         step();
         step();
      end
      pins_in = 4'h7;
      for (int i = 1; i <= 6; i++) begin
         step();
         check($sformatf("s3_pre%0d", i), data_ready, 1'b0);
      end
      step();
      check("s3_ready", data_ready, 1'b1);
      check("s3_ovr", overrun, 1'b0);
      read_expect("s3_read", 4'h7);

      // Scenario 4: two unread captures raise overrun, read returns latest
      apply_and_capture(4'h1);
      check("s4_ready1", data_ready, 1'b1);
      check("s4_ovr1", overrun, 1'b0);
      apply_and_capture(4'h2);
      check("s4_ready2", data_ready, 1'b1);
      check("s4_ovr2", overrun, 1'b1);
      read_expect("s4_read", 4'h2);

      // Scenario 5: read coincides with capture of C while 9 is held
      apply_and_capture(4'h8);
      apply_and_capture(4'h9);
      check("s5_ovr_pre", overrun, 1'b1);
      pins_in = 4'hC;
      repeat (6) step();
      check("s5_ready_pre", data_ready, 1'b1);
      enableIn = 1'b1;
      #1;
      check("s5_old_data", data_out, 4'h9);
      step();
      enableIn = 1'b0;
      #1;
      check("s5_ready", data_ready, 1'b1);
      check("s5_ovr", overrun, 1'b0);
      read_expect("s5_read", 4'hC);

      // Scenario 6: reset during SETTLING on F
      apply_and_capture(4'hE);
      check("s6_ready_pre", data_ready, 1'b1);
      pins_in = 4'hF;
      repeat (4) step();
      check("s6_settling", dut.state, SETTLING);
      reset_n = 1'b0;
      #1;
      check("s6_rst_ready", data_ready, 1'b0);
      check("s6_rst_ovr", overrun, 1'b0);
      check("s6_rst_data", data_out, 4'h0);
      check("s6_rst_drive", bus_drive, 1'b0);
      check("s6_rst_state", dut.state, STABLE);
      step();
      reset_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         check($sformatf("s6_pre%0d", i), data_ready, 1'b0);
      end
      step();
      check("s6_ready", data_ready, 1'b1);
      read_expect("s6_read", 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
